// File: rtl/intblock_wb_stage_if.sv
// Bundle between the integer execution block, the writeback stage and the frontend:
// result/redirect inputs, registered writeback outputs and the flush handshake.
interface intblock_wb_stage_if #(
    parameter int PC_W   = 64,
    parameter int RID_W  = 7,
    parameter int PREG_W = 7,
    parameter int SQID_W = 5
);
    // Handshake: flush_valid/flush_robid/flush_target are offered while a redirect is
    // pending and stay stable until a replacement; a transfer happens in any cycle
    // where flush_valid and flush_ready are both high.
    logic              in_valid;
    logic              in_need_to_wb;
    logic [PREG_W-1:0] in_prd;
    logic [63:0]       in_result;
    logic [RID_W-1:0]  in_robid;
    logic [SQID_W-1:0] in_sqid;
    logic              in_redirect_valid;
    logic [PC_W-1:0]   in_redirect_target;
    logic              rob_flush;

    logic              wb_valid;
    logic              wb_need_to_wb;
    logic [PREG_W-1:0] wb_prd;
    logic [63:0]       wb_result;
    logic [RID_W-1:0]  wb_robid;
    logic [SQID_W-1:0] wb_sqid;

    logic              flush_valid;
    logic [RID_W-1:0]  flush_robid;
    logic [PC_W-1:0]   flush_target;
    logic              flush_ready;
    logic [31:0]       redirect_cnt;
    logic              dbg_pend;

    modport slave (
        input  in_valid, in_need_to_wb, in_prd, in_result, in_robid, in_sqid,
               in_redirect_valid, in_redirect_target, rob_flush, flush_ready,
        output wb_valid, wb_need_to_wb, wb_prd, wb_result, wb_robid, wb_sqid,
               flush_valid, flush_robid, flush_target, redirect_cnt, dbg_pend
    );

    modport master (
        output in_valid, in_need_to_wb, in_prd, in_result, in_robid, in_sqid,
               in_redirect_valid, in_redirect_target, rob_flush, flush_ready,
        input  wb_valid, wb_need_to_wb, wb_prd, wb_result, wb_robid, wb_sqid,
               flush_valid, flush_robid, flush_target, redirect_cnt, dbg_pend
    );
endinterface

// File: rtl/intblock_wb_stage.sv
// Writeback register plus oldest-redirect holder: squashes results younger than the
// pending redirect and offers that redirect to the frontend until it is accepted.
module intblock_wb_stage #(
    parameter int PC_W   = 64,
    parameter int RID_W  = 7,
    parameter int PREG_W = 7,
    parameter int SQID_W = 5
) (
    input logic                  clock,
    input logic                  reset_n,
    intblock_wb_stage_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [RID_W-1:0] red_robid;
    logic [PC_W-1:0]  red_target;
    logic             kill_in, accept_in, handshake, replace;
    logic             load_red, cnt_inc;

    // The MSB is a wrap bit: differing wrap bits invert the plain magnitude compare.
    function automatic logic older(input logic [RID_W-1:0] a, input logic [RID_W-1:0] b);
        return (a[RID_W-1] ^ b[RID_W-1]) ^ (a[RID_W-2:0] < b[RID_W-2:0]);
    endfunction

    assign kill_in   = bus.in_valid && (state == PEND) && older(red_robid, bus.in_robid);
    assign accept_in = bus.in_valid && bus.in_redirect_valid && !kill_in && !bus.rob_flush;
    assign handshake = (state == PEND) && bus.flush_ready;
    assign replace   = (state == PEND) && accept_in && older(bus.in_robid, red_robid);

    always_comb begin
        state_nxt = state;
        load_red  = 1'b0;
        cnt_inc   = 1'b0;
        if (bus.rob_flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_in) begin
                        load_red  = 1'b1;
                        state_nxt = PEND;
                    end
                end
                PEND: begin
                    // A replacement keeps us pending even if the old redirect was taken.
                    if (handshake) cnt_inc = 1'b1;
                    if (replace) begin
                        load_red = 1'b1;
                    end else if (handshake) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            red_robid        <= '0;
            red_target       <= '0;
            bus.redirect_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load_red) begin
                red_robid  <= bus.in_robid;
                red_target <= bus.in_redirect_target;
            end
            if (cnt_inc) bus.redirect_cnt <= bus.redirect_cnt + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.wb_valid      <= 1'b0;
            bus.wb_need_to_wb <= 1'b0;
            bus.wb_prd        <= '0;
            bus.wb_result     <= '0;
            bus.wb_robid      <= '0;
            bus.wb_sqid       <= '0;
        end else begin
            bus.wb_valid      <= bus.in_valid && !kill_in && !bus.rob_flush;
            bus.wb_need_to_wb <= bus.in_need_to_wb;
            bus.wb_prd        <= bus.in_prd;
            bus.wb_result     <= bus.in_result;
            bus.wb_robid      <= bus.in_robid;
            bus.wb_sqid       <= bus.in_sqid;
        end
    end

    assign bus.flush_valid  = (state == PEND);
    assign bus.flush_robid  = red_robid;
    assign bus.flush_target = red_target;
    assign bus.dbg_pend     = (state == PEND);
endmodule

// File: tb/tb_intblock_wb_stage.sv
// Bench for intblock_wb_stage: per-cycle vector table for flush/redirect behaviour,
// queue of expected writeback payloads, and an asynchronous reset sequence.
module tb_intblock_wb_stage;
  localparam int PW = 84;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  intblock_wb_stage_if #(.PC_W(64), .RID_W(7), .PREG_W(7), .SQID_W(5)) bus ();

  intblock_wb_stage #(.PC_W(64), .RID_W(7), .PREG_W(7), .SQID_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        v, rd, rf, fr, need;
    logic [6:0]  rid, prd;
    logic [63:0] tgt, res;
    logic [4:0]  sq;
    logic        ewb, efv;
    logic [6:0]  erid;
    logic [63:0] etgt;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[$];
  logic [PW-1:0] exp_q[$];
  int tests = 0;
  int failed = 0;

  function automatic vec_t mk(logic v, logic rd, logic [6:0] rid, logic [63:0] tgt,
                              logic rf, logic fr, logic ewb, logic efv,
                              logic [6:0] erid, logic [63:0] etgt, logic [31:0] ecnt);
    vec_t r;
    r.v = v; r.rd = rd; r.rid = rid; r.tgt = tgt; r.rf = rf; r.fr = fr;
    r.need = 1'($urandom_range(0, 1));
    r.prd  = 7'($urandom_range(0, 127));
    r.res  = {32'($urandom), 32'($urandom)};
    r.sq   = 5'($urandom_range(0, 31));
    r.ewb = ewb; r.efv = efv; r.erid = erid; r.etgt = etgt; r.ecnt = ecnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    bus.in_valid = r.v;
    bus.in_redirect_valid = r.rd;
    bus.in_robid = r.rid;
    bus.in_redirect_target = r.tgt;
    bus.rob_flush = r.rf;
    bus.flush_ready = r.fr;
    bus.in_need_to_wb = r.need;
    bus.in_prd = r.prd;
    bus.in_result = r.res;
    bus.in_sqid = r.sq;
  endtask

  task automatic idle_inputs();
    vec_t z;
    z = mk(0, 0, 7'd0, 64'd0, 0, 0, 0, 0, 7'd0, 64'd0, 32'd0);
    drive(z);
  endtask

  // Compares writeback valid and, when valid, the oldest queued expected payload.
  task automatic check_wb(input string name, input logic exp_valid);
    logic [PW-1:0] e;
    chk({name, ".wb_valid"}, 128'(bus.wb_valid), 128'(exp_valid));
    if (bus.wb_valid) begin
      if (exp_q.size() == 0) begin
        tests++; failed++;
        $display("FAIL %s.wb_payload: got unexpected writeback, expected none queued", name);
      end else begin
        e = exp_q.pop_front();
        chk({name, ".wb_payload"},
            128'({bus.wb_need_to_wb, bus.wb_prd, bus.wb_result, bus.wb_robid, bus.wb_sqid}),
            128'(e));
      end
    end
  endtask

  initial begin
    vec_t r;
    vec_t p;
    idle_inputs();

    // Plain result
    p = mk(1, 0, 7'd3,  64'd0, 0, 0, 1, 0, 7'd0,  64'd0, 0);
    p.prd = 7'd5; p.res = 64'h1234;
    vecs.push_back(p);
    // Redirect handshake: ready low three cycles in PEND
    vecs.push_back(mk(1, 1, 7'd10, 64'h8000_0040, 0, 0, 1, 1, 7'd10, 64'h8000_0040, 0));
    vecs.push_back(mk(0, 0, 7'd0,  64'd0, 0, 0, 0, 1, 7'd10, 64'h8000_0040, 0));
    vecs.push_back(mk(0, 0, 7'd0,  64'd0, 0, 0, 0, 1, 7'd10, 64'h8000_0040, 0));
    vecs.push_back(mk(0, 0, 7'd0,  64'd0, 0, 0, 0, 1, 7'd10, 64'h8000_0040, 0));
    vecs.push_back(mk(0, 0, 7'd0,  64'd0, 0, 1, 0, 0, 7'd10, 64'h8000_0040, 1));
    // Kill younger, replace with older
    vecs.push_back(mk(1, 1, 7'd10, 64'hA000, 0, 0, 1, 1, 7'd10, 64'hA000, 1));
    vecs.push_back(mk(1, 1, 7'd12, 64'hB000, 0, 0, 0, 1, 7'd10, 64'hA000, 1));
    vecs.push_back(mk(1, 1, 7'd8,  64'hC000, 0, 0, 1, 1, 7'd8,  64'hC000, 1));
    vecs.push_back(mk(1, 0, 7'd9,  64'd0,    0, 1, 0, 0, 7'd8,  64'hC000, 2));
    // Wrap: 7E pending kills 01, keeps older 7D
    vecs.push_back(mk(1, 1, 7'h7E, 64'hD000, 0, 0, 1, 1, 7'h7E, 64'hD000, 2));
    vecs.push_back(mk(1, 1, 7'h01, 64'hE000, 0, 0, 0, 1, 7'h7E, 64'hD000, 2));
    vecs.push_back(mk(1, 0, 7'h7D, 64'd0,    0, 0, 1, 1, 7'h7E, 64'hD000, 2));
    vecs.push_back(mk(0, 0, 7'd0,  64'd0,    0, 1, 0, 0, 7'h7E, 64'hD000, 3));
    // Wrap: 7F replaces pending 02, with same-cycle handshake counted
    vecs.push_back(mk(1, 1, 7'h02, 64'h1000, 0, 0, 1, 1, 7'h02, 64'h1000, 3));
    vecs.push_back(mk(1, 1, 7'h7F, 64'h2000, 0, 1, 1, 1, 7'h7F, 64'h2000, 4));
    // Equal id is not older: not killed
    vecs.push_back(mk(1, 0, 7'h7F, 64'd0,    0, 0, 1, 1, 7'h7F, 64'h2000, 4));
    // rob_flush with handshake and older redirect: everything dropped, count unchanged
    vecs.push_back(mk(1, 1, 7'h70, 64'h3000, 1, 1, 0, 0, 7'h7F, 64'h2000, 4));
    // flush_ready tied high
    vecs.push_back(mk(1, 1, 7'h20, 64'h4000, 0, 1, 1, 1, 7'h20, 64'h4000, 4));
    vecs.push_back(mk(1, 1, 7'h21, 64'h5000, 0, 1, 0, 0, 7'h20, 64'h4000, 5));
    vecs.push_back(mk(1, 1, 7'h22, 64'h6000, 0, 1, 1, 1, 7'h22, 64'h6000, 5));
    vecs.push_back(mk(0, 0, 7'd0,  64'd0,    0, 1, 0, 0, 7'h22, 64'h6000, 6));

    // Reset state
    #12;
    chk("reset.wb_valid", 128'(bus.wb_valid), 128'(0));
    chk("reset.flush_valid", 128'(bus.flush_valid), 128'(0));
    chk("reset.redirect_cnt", 128'(bus.redirect_cnt), 128'(0));
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      r = vecs[i];
      @(negedge clock);
      drive(r);
      if (r.ewb) exp_q.push_back({r.need, r.prd, r.res, r.rid, r.sq});
      @(posedge clock);
      #1;
      check_wb($sformatf("vec%0d", i), r.ewb);
      chk($sformatf("vec%0d.flush_valid", i), 128'(bus.flush_valid), 128'(r.efv));
      chk($sformatf("vec%0d.dbg_pend", i), 128'(bus.dbg_pend), 128'(r.efv));
      chk($sformatf("vec%0d.flush_robid", i), 128'(bus.flush_robid), 128'(r.erid));
      chk($sformatf("vec%0d.flush_target", i), 128'(bus.flush_target), 128'(r.etgt));
      chk($sformatf("vec%0d.redirect_cnt", i), 128'(bus.redirect_cnt), 128'(r.ecnt));
    end

    // Asynchronous reset asserted while a redirect is pending
    @(negedge clock);
    r = mk(1, 1, 7'h33, 64'h7000, 0, 0, 1, 1, 7'h33, 64'h7000, 6);
    drive(r);
    exp_q.push_back({r.need, r.prd, r.res, r.rid, r.sq});
    @(posedge clock);
    #1;
    check_wb("areset.pre", 1'b1);
    chk("areset.pre.flush_valid", 128'(bus.flush_valid), 128'(1));
    @(negedge clock);
    idle_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset.wb_valid", 128'(bus.wb_valid), 128'(0));
    chk("areset.wb_result", 128'(bus.wb_result), 128'(0));
    chk("areset.flush_valid", 128'(bus.flush_valid), 128'(0));
    chk("areset.flush_robid", 128'(bus.flush_robid), 128'(0));
    chk("areset.flush_target", 128'(bus.flush_target), 128'(0));
    chk("areset.redirect_cnt", 128'(bus.redirect_cnt), 128'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("post_reset.flush_valid", 128'(bus.flush_valid), 128'(0));
    chk("post_reset.wb_valid", 128'(bus.wb_valid), 128'(0));
    chk("scoreboard.drained", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
